// File: rtl/monster_game_ctrl.sv
// monster_game_ctrl: game-rule sequencer for the monster-jump LED game.
// Owns the play state (idle/run/over), divides the tick enable into game
// steps, and produces the monster height, the scrolling barrier bitmap and
// the score for the display logic to render.
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-high reset
//   up         one-clk jump/start pulse (debounced)
//   tick       one-clk step enable from the barrier clock divider
//   state      2'd0 idle, 2'd1 run, 2'd2 game over
//   monster_h  monster height above ground (0..3), monster sits in column 1
//   barrier    ground-row barrier bitmap, bit i is column i
//   score      barriers passed, saturating at 255
module monster_game_ctrl #(
    parameter int unsigned SPEED0 = 4,
    parameter logic [7:0]  SEED   = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       up,
    input  logic       tick,
    output logic [1:0] state,
    output logic [1:0] monster_h,
    output logic [7:0] barrier,
    output logic [7:0] score
);

    localparam int unsigned PW = 4;  // period / tick-counter width
    localparam int unsigned JW = 3;  // jump phase width

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_OVER = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [1:0]      monster_h_q, monster_h_d;
    logic [7:0]      barrier_q, barrier_d;
    logic [7:0]      score_q, score_d;
    logic [7:0]      lfsr_q, lfsr_d;
    logic [PW-1:0]   period_q, period_d;
    logic [PW-1:0]   pc_q, pc_d;
    logic [JW-1:0]   jphase_q, jphase_d;
    logic            jreq_q, jreq_d;

    logic            step_c;
    logic            spawn_c;
    logic [7:0]      bar_nxt_c;

    // Jump height profile: up three rows, hang one step, come back down.
    function automatic logic [1:0] jump_height(input logic [JW-1:0] ph);
        logic [1:0] h;
        case (ph)
            3'd1, 3'd6: h = 2'd1;
            3'd2, 3'd5: h = 2'd2;
            3'd3, 3'd4: h = 2'd3;
            default:    h = 2'd0;
        endcase
        return h;
    endfunction

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            monster_h_q <= 2'd0;
            barrier_q   <= 8'd0;
            score_q     <= 8'd0;
            lfsr_q      <= SEED;
            period_q    <= PW'(SPEED0);
            pc_q        <= '0;
            jphase_q    <= '0;
            jreq_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            monster_h_q <= monster_h_d;
            barrier_q   <= barrier_d;
            score_q     <= score_d;
            lfsr_q      <= lfsr_d;
            period_q    <= period_d;
            pc_q        <= pc_d;
            jphase_q    <= jphase_d;
            jreq_q      <= jreq_d;
        end
    end

    // Next-state: play state, step scheduler and per-step game rules
    always_comb begin
        state_d     = state_q;
        monster_h_d = monster_h_q;
        barrier_d   = barrier_q;
        score_d     = score_q;
        period_d    = period_q;
        pc_d        = pc_q;
        jphase_d    = jphase_q;
        jreq_d      = jreq_q;
        step_c      = 1'b0;

        // Fibonacci LFSR, taps 8,6,5,4; free-running in every state
        lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

        // Spawning only into an empty top three columns keeps a 3-column gap
        spawn_c   = (lfsr_q[2:0] == 3'd0) && (barrier_q[7:5] == 3'd0);
        bar_nxt_c = {spawn_c, barrier_q[7:1]};

        unique case (state_q)
            ST_RUN: begin
                if (tick && (pc_q == '0)) begin
                    step_c = 1'b1;
                end else if (tick) begin
                    pc_d = pc_q - PW'(1);
                end

                if (step_c) begin
                    pc_d = period_q - PW'(1);
                    if ((jphase_q == '0) && (jreq_q || up)) begin
                        jphase_d = JW'(1);
                        jreq_d   = 1'b0;
                    end else if (jphase_q != '0) begin
                        jphase_d = (jphase_q == JW'(6)) ? '0 : jphase_q + JW'(1);
                    end
                    monster_h_d = jump_height(jphase_d);
                    barrier_d   = bar_nxt_c;

                    // Score the barrier leaving column 0; speed up every 16 passes
                    if (barrier_q[0] && (score_q != 8'hFF)) begin
                        score_d = score_q + 8'd1;
                        if ((score_d[3:0] == 4'd0) && (period_q > PW'(1))) begin
                            period_d = period_q - PW'(1);
                        end
                    end

                    // Step results still commit on the colliding step
                    if (bar_nxt_c[1] && (monster_h_d == 2'd0)) begin
                        state_d = ST_OVER;
                    end
                end else if (up && (jphase_q == '0) && (monster_h_q == 2'd0)) begin
                    jreq_d = 1'b1;
                end
            end
            default: begin
                // Idle and game-over hold everything until a start press
                if (up) begin
                    state_d     = ST_RUN;
                    monster_h_d = 2'd0;
                    barrier_d   = 8'd0;
                    score_d     = 8'd0;
                    period_d    = PW'(SPEED0);
                    pc_d        = '0;
                    jphase_d    = '0;
                    jreq_d      = 1'b0;
                end
            end
        endcase
    end

    assign state     = state_q;
    assign monster_h = monster_h_q;
    assign barrier   = barrier_q;
    assign score     = score_q;

endmodule

// File: doc/monster_game_ctrl.md
# monster_game_ctrl

Game-sequencing controller for the monster-jump LED game: it owns the play state (idle / run / game-over), schedules game steps from a slow tick enable, and produces the monster height, the scrolling barrier bitmap and the score. The debounced jump pulse feeds into it. Its outputs drive the 8x8 matrix display and the score display. The block takes over game-rule sequencing so the display logic only renders.

## Interface
- `SPEED0`, default 4: initial number of ticks per game step (1..15).
- `SEED`, default 8'hA5: LFSR reset value (must be non-zero).
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `up` in 1: one-clk jump/start pulse from the debouncer.
- `tick` in 1: one-clk step enable from the barrier clock divider.
- `state` out 2: 2'd0 IDLE, 2'd1 RUN, 2'd2 OVER.
- `monster_h` out 2: monster height above ground, 0..3; the monster is in column 1.
- `barrier` out 8: ground-row barrier bitmap; bit i is column i.
- `score` out 8: barriers passed, saturating at 255.

## Operation
- All outputs are registered. Reset values:
  - `state`=0, `monster_h`=0, `barrier`=0, `score`=0.
  - Internal registers: `lfsr`=SEED, `period`=SPEED0, `pc`=0, `jphase`=0, `jreq`=0.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4. Shifts every clk in every state.
- IDLE or OVER, on `up`: go to RUN.
  - Clear `barrier`, `score`, `monster_h`, `jphase`, `jreq` and `pc`.
  - Set `period`=SPEED0.
  - `tick` is ignored on that clk.
- OVER: all outputs frozen except via `up`.
- RUN, on `up`: set `jreq` only if `jphase`==0 and `monster_h`==0. Otherwise ignore the pulse.
- RUN step scheduler:
  - On `tick`, a step occurs when `pc`==0, and `pc` reloads with `period`-1.
  - On `tick` with `pc`!=0, `pc` decrements.
- On each step:
  - Jump: if `jphase`==0 and (`jreq` or `up` this clk), set `jphase`=1 and clear `jreq`.
  - Else if `jphase`!=0, `jphase` advances; after 6 it returns to 0.
  - `monster_h` by `jphase` 1..6 is 1,2,3,3,2,1; it is 0 when `jphase`==0.
  - Barrier: `barrier_next[i]`=`barrier[i+1]` for i=0..6, and `barrier_next[7]`=`spawn`.
  - `spawn` = (`lfsr[2:0]`==0) and (`barrier[7:5]`==0). This guarantees a minimum gap of 3 columns.
  - Score: if `barrier[0]`==1 (shifted out), `score` increments, saturating at 255.
  - When the increment makes `score[3:0]`==0 and `period`>1, `period` decrements.
  - Collision: if `barrier_next[1]`==1 and `monster_h_next`==0, `state` goes to OVER. The step's `barrier`, `monster_h` and `score` updates still commit.
- Simultaneous events:
  - `up` and a step on the same clk: the jump starts on that step.
  - `up` on the transition clk from IDLE/OVER: starts the game only; no jump is queued.
  - Score saturation and the period floor of 1 both hold indefinitely.
- Reset mid-game: immediate return to all reset values, regardless of clk.

## Timing
- Step decision is made on the clk where `tick`=1 and `pc`==0. All step results are visible on the following clk edge, with 1-clk latency.
- With a steady `tick`, step spacing is `period` ticks.
- The start transition and the OVER transition are each visible 1 clk after the causing edge.
- The jump is airborne for exactly 6 steps.

## Test plan
- Reset: assert `rst` mid-RUN with `score`=5 → same cycle: `state`=0, `barrier`=0, `score`=0, `monster_h`=0. Release it, pulse `up` → `state`=1 next clk.
- Jump profile: RUN, SPEED0=1, pulse `up` before a step → over successive steps `monster_h`=1,2,3,3,2,1,0. A second `up` while airborne has no effect.
- Scheduler: SPEED0=4, `tick` every clk → steps (barrier shifts) on every 4th tick. Force 16 passes → spacing becomes 3 ticks.
- Collision: no jumps → on the step where a barrier enters bit 1, `state`=2 one clk later. `barrier` and `score` then stay frozen for 100 more ticks.
- Clear: `up` pressed when a barrier sits in bit 2 → barrier passes bits 1 and 0 with `monster_h` of 1 and 2. On the next step `score`=1 and `state` remains 1.
- Restart from OVER with `up` → `state`=1, `score`=0, `barrier`=0. `monster_h` stays 0, with no queued jump.
